// File: rtl/ddfs_pkg.sv
// Shared constants and types for the DDFS sweep controller.
// The frequency-word width must match the DDFS phase accumulator.
package ddfs_pkg;
    localparam int FW = 23;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/ddfs_step_calc.sv
// Next-word arithmetic for one sweep leg: steps toward target and clamps on it,
// so the word can neither wrap past 2^FW nor underflow below zero.
module ddfs_step_calc #(
    parameter int FW = ddfs_pkg::FW
) (
    input  logic [FW-1:0] f,
    input  logic [FW-1:0] step,
    input  logic [FW-1:0] target,
    input  logic          dir,
    output logic [FW-1:0] next,
    output logic          at_end
);
    import ddfs_pkg::*;

    logic [FW:0]   sum;
    logic [FW-1:0] diff;

    assign sum  = {1'b0, f} + {1'b0, step};
    assign diff = f - target;

    always_comb begin
        at_end = (f == target);
        if (!dir) begin
            next = (sum >= {1'b0, target}) ? target : sum[FW-1:0];
        end else begin
            next = (diff <= step) ? target : (f - step);
        end
    end
endmodule

// File: rtl/ddfs_sweep_ctrl.sv
// Linear frequency-sweep generator feeding the DDFS fcontrol input.
// Single, sawtooth-repeat and triangle sweeps with per-word dwell.
module ddfs_sweep_ctrl #(
    parameter int FW = ddfs_pkg::FW,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop_req,
    input  logic [1:0]    mode,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    output logic [FW-1:0] fcontrol,
    output logic          busy,
    output logic          done,
    output logic          dir
);
    import ddfs_pkg::*;

    state_t        state, state_nxt;
    logic [FW-1:0] fcontrol_nxt;
    logic          busy_nxt, done_nxt, dir_nxt, load;
    logic [DW-1:0] cnt, cnt_nxt;

    logic [1:0]    mode_q;
    logic [FW-1:0] start_q, stop_q, step_q;
    logic [DW-1:0] dwell_q;
    logic          dir0_q;

    logic [FW-1:0] target, alt_target, step_next, turn_next;
    logic          at_end, alt_at_end, degenerate;

    // The leg heading back to f_stop uses the launch direction; the return leg targets f_start.
    assign target     = (dir == dir0_q) ? stop_q  : start_q;
    assign alt_target = (dir == dir0_q) ? start_q : stop_q;

    ddfs_step_calc #(.FW(FW)) u_calc (
        .f      (fcontrol),
        .step   (step_q),
        .target (target),
        .dir    (dir),
        .next   (step_next),
        .at_end (at_end)
    );

    ddfs_step_calc #(.FW(FW)) u_turn (
        .f      (fcontrol),
        .step   (step_q),
        .target (alt_target),
        .dir    (~dir),
        .next   (turn_next),
        .at_end (alt_at_end)
    );

    // Both endpoints coinciding with the current word means f_start == f_stop.
    assign degenerate = (step_q == '0) || (at_end && alt_at_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fcontrol <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dir      <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            fcontrol <= fcontrol_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            dir      <= dir_nxt;
            cnt      <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_SINGLE;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            dir0_q  <= 1'b0;
        end else if (load) begin
            mode_q  <= mode;
            start_q <= f_start;
            stop_q  <= f_stop;
            step_q  <= f_step;
            dwell_q <= dwell;
            dir0_q  <= (f_stop < f_start);
        end
    end

    always_comb begin
        state_nxt    = state;
        fcontrol_nxt = fcontrol;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        dir_nxt      = dir;
        cnt_nxt      = cnt;
        load         = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load         = 1'b1;
                    fcontrol_nxt = f_start;
                    busy_nxt     = 1'b1;
                    dir_nxt      = (f_stop < f_start);
                    cnt_nxt      = dwell;
                    state_nxt    = RUN;
                end
            end
            RUN: begin
                if (stop_req) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - DW'(1);
                end else begin
                    cnt_nxt = dwell_q;
                    if (degenerate || (at_end && mode_q != MODE_SAW && mode_q != MODE_TRI)) begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else if (at_end && mode_q == MODE_SAW) begin
                        fcontrol_nxt = start_q;
                    end else if (at_end) begin
                        dir_nxt      = ~dir;
                        fcontrol_nxt = turn_next;
                    end else begin
                        fcontrol_nxt = step_next;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
